vga_timing_controller: RTL and testbench
========================================

Name: vga_timing_controller

Overview:
- Generates VGA raster timing for the display path: pixel tick, horizontal/vertical counters, hsync/vsync, and the `row`/`col` coordinates consumed by the pixel drawer.
- Samples the drawer's combinational RGB answer and registers it to the DAC pins, aligned with the sync signals.
- Supplies `frame_start` and `vblank` so game logic (Mario position, background map) updates only outside the visible region.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz clk -> 25 MHz pixel); legal range 1..16
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses driven low

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- red_in  input  4  drawer red for current row/col
- green_in  input  4  drawer green
- blue_in  input  4  drawer blue
- row  output  32 (int)  current visible line, 0..V_VISIBLE-1
- col  output  32 (int)  current visible pixel, 0..H_VISIBLE-1
- video_on  output  1  row/col currently in visible region
- hsync  output  1  horizontal sync to connector
- vsync  output  1  vertical sync to connector
- red  output  4  registered red to DAC
- green  output  4  registered green to DAC
- blue  output  4  registered blue to DAC
- frame_start  output  1  one-clk pulse at pixel (0,0) of each frame
- vblank  output  1  high while v_count >= V_VISIBLE

Behaviour:
- Reset (async assert, sync release):
  - Internal counters: div_cnt=0, h_count=0, v_count=0.
  - Outputs: row=0, col=0, video_on=0, red=green=blue=0, frame_start=0, vblank=0.
  - hsync and vsync at their inactive level (1 when SYNC_ACTIVE_LOW).
- Pixel tick:
  - div_cnt counts 0..CLK_DIV-1 and wraps; tick asserts when div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, tick is constantly high.
- Counters (advance only on tick):
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (800).
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (525).
  - h_count wraps H_TOTAL-1 -> 0; v_count increments only on that wrap.
  - v_count wraps V_TOTAL-1 -> 0 on the same tick as the h wrap.
- Stage 0 (registered on tick from next counter values):
  - video_on = (h < H_VISIBLE) && (v < V_VISIBLE).
  - col = h and row = v while visible; otherwise col=0, row=0, so the drawer's map index (row/40, col/40) never exceeds 11/15.
- Stage 1 (registered on tick, one pixel after stage 0):
  - red/green/blue = video_on_d ? *_in : 0, where video_on_d is stage-0 video_on.
  - hsync active while H_VISIBLE+H_FRONT <= h_d < H_VISIBLE+H_FRONT+H_SYNC (h_d = stage-0-delayed h_count).
  - vsync decoded the same way from v_d over the V_* parameters.
  - Result: RGB and sync are mutually aligned, one pixel tick after row/col.
- Drawer contract: red_in/green_in/blue_in are combinational from row/col and must settle within one pixel period.
- frame_start: one clk wide; asserted on the tick on which stage-0 row/col become (0,0).
- vblank: registered with stage 0; rises on the tick stage 0 leaves line V_VISIBLE-1 and falls on the tick it enters line 0.
- Between ticks every output holds its value.
- Reset asserted mid-frame: all outputs return to reset values immediately. After release, the first tick starts the frame at (0,0) with frame_start pulsed.
- Widths:
  - Internal counters are unsigned, sized $clog2(H_TOTAL) and $clog2(V_TOTAL).
  - row/col are zero-extended to 32-bit int; never negative.

Test Plan:
- Reset, CLK_DIV=2 -> hsync=vsync=1, RGB=0, row=col=0. After release: first tick at clk 2, with frame_start high for exactly one clk, col=0, row=0, video_on=1.
- Run one line -> exactly 1600 clks between hsync falling edges. Low width 192 clks. Falling edge 656 ticks after the col=0 tick of that line plus 1-tick pipeline.
- Run full frame -> vsync low for 2 lines (3200 clks). frame_start period 840000 clks. vblank high for 45 lines.
- Drive red_in=row[3:0], green_in=col[3:0], blue_in=4'hA -> at the DAC, pixel (col=5,row=3) shows red=3, green=5, blue=A one tick after row/col=(3,5). RGB=0 whenever col output is held at 0 during blanking.
- Check row/col bounds across a whole frame -> col never exceeds 639 and row never exceeds 479. Both read 0 whenever video_on=0.
- Assert reset_n at line 200, pixel 300, for 3 clks -> outputs reset asynchronously. The next frame_start occurs on the first tick after release, followed by a full 800x525 frame.

Source files
------------

// File: rtl/vga_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_controller
//  Purpose  : VGA raster timing generator. It produces the pixel tick,
//             the horizontal and vertical counters, hsync and vsync, and the
//             row/col coordinates used by the pixel drawer. It also registers
//             the drawer's RGB answer onto the DAC pins so that colour and
//             sync arrive together, and it provides frame_start and vblank
//             for the game-logic update window.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1  system clock
//    reset_n     in   1  asynchronous active-low reset (released synchronously)
//    red_in      in   4  drawer red for the current row/col
//    green_in    in   4  drawer green for the current row/col
//    blue_in     in   4  drawer blue for the current row/col
//    row         out 32  current visible line (0 while blanking)
//    col         out 32  current visible pixel (0 while blanking)
//    video_on    out  1  row/col lie inside the visible region
//    hsync       out  1  horizontal sync to the connector
//    vsync       out  1  vertical sync to the connector
//    red         out  4  registered red to the DAC
//    green       out  4  registered green to the DAC
//    blue        out  4  registered blue to the DAC
//    frame_start out  1  one-clk pulse when row/col become (0,0)
//    vblank      out  1  high while the current line is outside the picture
// ============================================================================
module vga_timing_controller #(
  parameter int CLK_DIV         = 2,
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  red_in,
  input  logic [3:0]  green_in,
  input  logic [3:0]  blue_in,
  output logic [31:0] row,
  output logic [31:0] col,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_start,
  output logic        vblank
);

  // --------------------------------------------------------------------------
  // Geometry constants
  // --------------------------------------------------------------------------
  localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int c_hw      = $clog2(c_h_total);
  localparam int c_vw      = $clog2(c_v_total);

  localparam logic [c_hw-1:0] c_h_max      = c_hw'(c_h_total - 1);
  localparam logic [c_hw-1:0] c_h_vis      = c_hw'(H_VISIBLE);
  localparam logic [c_hw-1:0] c_hs_start   = c_hw'(H_VISIBLE + H_FRONT);
  // Sync end may equal the total (no back porch), so it gets one spare bit.
  localparam logic [c_hw:0]   c_hs_end     = (c_hw + 1)'(H_VISIBLE + H_FRONT + H_SYNC);

  localparam logic [c_vw-1:0] c_v_max      = c_vw'(c_v_total - 1);
  localparam logic [c_vw-1:0] c_v_vis      = c_vw'(V_VISIBLE);
  localparam logic [c_vw-1:0] c_vs_start   = c_vw'(V_VISIBLE + V_FRONT);
  localparam logic [c_vw:0]   c_vs_end     = (c_vw + 1)'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic c_sync_off = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic c_sync_on  = ~c_sync_off;

  // --------------------------------------------------------------------------
  // Pixel tick
  // --------------------------------------------------------------------------
  logic w_tick;

  generate
    if (CLK_DIV == 1) begin : g_tick_every_clk
      assign w_tick = 1'b1;
    end else begin : g_tick_divided
      localparam int c_dw = $clog2(CLK_DIV);
      localparam logic [c_dw-1:0] c_div_max = c_dw'(CLK_DIV - 1);

      logic [c_dw-1:0] r_div_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_div_cnt <= '0;
        end else if (r_div_cnt == c_div_max) begin
          r_div_cnt <= '0;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end

      // The tick lands on the last clock of each pixel period, so the first
      // tick after reset release occurs CLK_DIV clocks later.
      assign w_tick = (r_div_cnt == c_div_max);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Raster counters
  // The counters hold the position that the next tick loads into stage 0.
  // Starting them at (0,0) makes the first tick after reset present pixel
  // (0,0) on row/col together with frame_start.
  // --------------------------------------------------------------------------
  logic [c_hw-1:0] r_h_count;
  logic [c_vw-1:0] r_v_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (w_tick) begin
      if (r_h_count == c_h_max) begin
        r_h_count <= '0;
        if (r_v_count == c_v_max) begin
          r_v_count <= '0;
        end else begin
          r_v_count <= r_v_count + 1'b1;
        end
      end else begin
        r_h_count <= r_h_count + 1'b1;
      end
    end
  end

  logic w_h_vis;
  logic w_v_vis;
  logic w_vis;

  assign w_h_vis = (r_h_count < c_h_vis);
  assign w_v_vis = (r_v_count < c_v_vis);
  assign w_vis   = w_h_vis && w_v_vis;

  // --------------------------------------------------------------------------
  // Stage 0: coordinates presented to the drawer
  // row/col are forced to 0 in blanking so the drawer's tile index never
  // runs past the edge of its map.
  // --------------------------------------------------------------------------
  logic [c_hw-1:0] r_h_d;
  logic [c_vw-1:0] r_v_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row         <= '0;
      col         <= '0;
      video_on    <= 1'b0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
      r_h_d       <= '0;
      r_v_d       <= '0;
    end else begin
      // Cleared on every clock so the pulse is one clk wide for any CLK_DIV.
      frame_start <= w_tick && (r_h_count == '0) && (r_v_count == '0);
      if (w_tick) begin
        video_on <= w_vis;
        col      <= w_vis ? 32'(r_h_count) : 32'd0;
        row      <= w_vis ? 32'(r_v_count) : 32'd0;
        vblank   <= !w_v_vis;
        r_h_d    <= r_h_count;
        r_v_d    <= r_v_count;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: DAC colour and sync, one pixel behind row/col
  // Sync is decoded from the stage-0 copy of the counters so it stays aligned
  // with the colour sampled from the drawer for that same pixel.
  // --------------------------------------------------------------------------
  logic w_hs_act;
  logic w_vs_act;

  assign w_hs_act = (r_h_d >= c_hs_start) && ({1'b0, r_h_d} < c_hs_end);
  assign w_vs_act = (r_v_d >= c_vs_start) && ({1'b0, r_v_d} < c_vs_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= c_sync_off;
      vsync <= c_sync_off;
    end else if (w_tick) begin
      red   <= video_on ? red_in   : 4'd0;
      green <= video_on ? green_in : 4'd0;
      blue  <= video_on ? blue_in  : 4'd0;
      hsync <= w_hs_act ? c_sync_on : c_sync_off;
      vsync <= w_vs_act ? c_sync_on : c_sync_off;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_controller
//  Purpose  : Self-checking bench for vga_timing_controller. Three instances:
//             default 640x480 timing, a small active-high-sync geometry with
//             CLK_DIV=3 for whole-frame behaviour, and a tiny CLK_DIV=1 one.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_controller;

  typedef struct packed {
    int d; int hv; int hf; int hs; int hb; int vv; int vf; int vs; int vb; int al;
  } geom_t;

  typedef struct packed {
    logic [31:0] row;
    logic [31:0] col;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        frame_start;
    logic        vblank;
  } obs_t;

  localparam geom_t GA = '{d:2, hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, al:1};
  localparam geom_t GB = '{d:3, hv:20, hf:4, hs:6, hb:5, vv:12, vf:2, vs:2, vb:3, al:0};
  localparam geom_t GC = '{d:1, hv:8, hf:2, hs:3, hb:2, vv:5, vf:1, vs:1, vb:2, al:1};

  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- instance A: default parameters ----------------
  logic [31:0] row_a, col_a;
  logic        vo_a, hs_a, vs_a, fs_a, vb_a;
  logic [3:0]  r_a, g_a, b_a, ri_a, gi_a, bi_a;
  assign ri_a = row_a[3:0];
  assign gi_a = col_a[3:0];
  assign bi_a = 4'hA;

  vga_timing_controller dut_a (
    .clk(clk), .reset_n(rst_a), .red_in(ri_a), .green_in(gi_a), .blue_in(bi_a),
    .row(row_a), .col(col_a), .video_on(vo_a), .hsync(hs_a), .vsync(vs_a),
    .red(r_a), .green(g_a), .blue(b_a), .frame_start(fs_a), .vblank(vb_a)
  );

  // ---------------- instance B: small frame, CLK_DIV=3, active-high sync ---
  logic [31:0] row_b, col_b;
  logic        vo_b, hs_b, vs_b, fs_b, vb_b;
  logic [3:0]  r_b, g_b, b_b, ri_b, gi_b, bi_b;
  assign ri_b = row_b[3:0];
  assign gi_b = col_b[3:0];
  assign bi_b = 4'hA;

  vga_timing_controller #(
    .CLK_DIV(3), .H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE_LOW(0)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .red_in(ri_b), .green_in(gi_b), .blue_in(bi_b),
    .row(row_b), .col(col_b), .video_on(vo_b), .hsync(hs_b), .vsync(vs_b),
    .red(r_b), .green(g_b), .blue(b_b), .frame_start(fs_b), .vblank(vb_b)
  );

  // ---------------- instance C: tiny frame, CLK_DIV=1 ----------------
  logic [31:0] row_c, col_c;
  logic        vo_c, hs_c, vs_c, fs_c, vb_c;
  logic [3:0]  r_c, g_c, b_c, ri_c, gi_c, bi_c;
  assign ri_c = row_c[3:0];
  assign gi_c = col_c[3:0];
  assign bi_c = 4'hA;

  vga_timing_controller #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .SYNC_ACTIVE_LOW(1)
  ) dut_c (
    .clk(clk), .reset_n(rst_b), .red_in(ri_c), .green_in(gi_c), .blue_in(bi_c),
    .row(row_c), .col(col_c), .video_on(vo_c), .hsync(hs_c), .vsync(vs_c),
    .red(r_c), .green(g_c), .blue(b_c), .frame_start(fs_c), .vblank(vb_c)
  );

  obs_t oa, ob, oc;
  assign oa = {row_a, col_a, vo_a, hs_a, vs_a, r_a, g_a, b_a, fs_a, vb_a};
  assign ob = {row_b, col_b, vo_b, hs_b, vs_b, r_b, g_b, b_b, fs_b, vb_b};
  assign oc = {row_c, col_c, vo_c, hs_c, vs_c, r_c, g_c, b_c, fs_c, vb_c};

  // Clock edges seen since the matching reset was released.
  longint na, nb;
  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) na <= 0;
    else        na <= na + 1;
  end
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) nb <= 0;
    else        nb <= nb + 1;
  end

  // Expected outputs after n clock edges out of reset, from raster arithmetic:
  // tick k shows linear pixel k-1 on row/col, and pixel k-2 at the DAC/sync.
  function automatic obs_t model(input geom_t g, input longint n);
    obs_t   e;
    longint k, p, q;
    int     ht, vt, h, v, hq, vq;
    logic   inact;
    ht    = g.hv + g.hf + g.hs + g.hb;
    vt    = g.vv + g.vf + g.vs + g.vb;
    inact = (g.al != 0);
    e       = '0;
    e.hsync = inact;
    e.vsync = inact;
    k = n / g.d;
    if (k >= 1) begin
      p = k - 1;
      h = int'(p % ht);
      v = int'((p / ht) % vt);
      e.video_on    = (h < g.hv) && (v < g.vv);
      e.col         = e.video_on ? 32'(h) : 32'd0;
      e.row         = e.video_on ? 32'(v) : 32'd0;
      e.vblank      = (v >= g.vv);
      e.frame_start = ((n % g.d) == 0) && ((p % (ht * vt)) == 0);
      if (k >= 2) begin
        q  = p - 1;
        hq = int'(q % ht);
        vq = int'((q / ht) % vt);
        if ((hq < g.hv) && (vq < g.vv)) begin
          e.red   = 4'(vq % 16);
          e.green = 4'(hq % 16);
          e.blue  = 4'hA;
        end
        if (hq >= g.hv + g.hf && hq < g.hv + g.hf + g.hs) e.hsync = ~inact;
        if (vq >= g.vv + g.vf && vq < g.vv + g.vf + g.vs) e.vsync = ~inact;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input longint exp);
    vectors++;
    if (act !== 64'(exp)) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_obs(input string nm, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of all three instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk_obs($sformatf("model_a n=%0d", na), oa, model(GA, na));
      chk_obs($sformatf("model_b n=%0d", nb), ob, model(GB, nb));
      chk_obs($sformatf("model_c n=%0d", nb), oc, model(GC, nb));
    end
  end

  // Default geometry: first tick, line timing, pixel (5,3) at the DAC.
  task automatic seq_a();
    longint fall1 = -1, fall2 = -1, rise1 = -1, px_n = -1, px_chk = -1;
    logic   prev_h = 1'b1;
    for (int i = 0; i < 5200; i++) begin
      @(negedge clk);
      if (na == 1) begin
        chk("a_fs_before_tick", fs_a, 0);
        chk("a_vo_before_tick", vo_a, 0);
      end
      if (na == 2) begin
        chk("a_fs_first_tick", fs_a, 1);
        chk("a_vo_first_tick", vo_a, 1);
        chk("a_row_first_tick", row_a, 0);
        chk("a_col_first_tick", col_a, 0);
      end
      if (na == 3) chk("a_fs_one_clk", fs_a, 0);
      if (na == 1282) begin
        chk("a_col_blank", col_a, 0);
        chk("a_vo_blank", vo_a, 0);
      end
      if (na == 1284) chk("a_rgb_blank", {r_a, g_a, b_a}, 0);
      if (prev_h && !hs_a) begin
        if (fall1 < 0) fall1 = na;
        else if (fall2 < 0) fall2 = na;
      end
      if (!prev_h && hs_a && fall1 >= 0 && rise1 < 0) rise1 = na;
      prev_h = hs_a;
      if (px_n < 0 && row_a == 3 && col_a == 5) begin
        px_n   = na;
        px_chk = na + 2;
      end
      if (na == px_chk) begin
        chk("a_px53_red", r_a, 3);
        chk("a_px53_green", g_a, 5);
        chk("a_px53_blue", b_a, 10);
      end
    end
    chk("a_hsync_first_fall", fall1, 1316);
    chk("a_hsync_period", fall2 - fall1, 1600);
    chk("a_hsync_low_width", rise1 - fall1, 192);
    chk("a_px53_at_clk", px_n, 4812);
  endtask

  // Small geometry: frame-level timing, bounds, mid-frame reset.
  task automatic seq_b();
    longint fs1 = -1, fs2 = -1, vs_r = -1, vs_f = -1, vk_r = -1, vk_f = -1;
    longint hs_r1 = -1, hs_r2 = -1, hs_f = -1, fsa = -1, fsb = -1;
    int     fs_w = 0, bad = 0;
    bit     found = 1'b0;
    logic   pfs = 1'b0, pvs = 1'b0, pvk = 1'b0, phs = 1'b0;
    obs_t   z = '0;
    for (int i = 0; i < 4500; i++) begin
      @(negedge clk);
      if (fs_b && !pfs) begin
        if (fs1 < 0) fs1 = nb;
        else if (fs2 < 0) fs2 = nb;
      end
      if (fs_b && nb < 1000) fs_w++;
      if (vs_b && !pvs && vs_r < 0) vs_r = nb;
      if (!vs_b && pvs && vs_r >= 0 && vs_f < 0) vs_f = nb;
      if (vb_b && !pvk && vk_r < 0) vk_r = nb;
      if (!vb_b && pvk && vk_r >= 0 && vk_f < 0) vk_f = nb;
      if (hs_b && !phs) begin
        if (hs_r1 < 0) hs_r1 = nb;
        else if (hs_r2 < 0) hs_r2 = nb;
      end
      if (!hs_b && phs && hs_r1 >= 0 && hs_f < 0) hs_f = nb;
      if (col_b > 19 || row_b > 11 || (!vo_b && (row_b != 0 || col_b != 0))) bad++;
      pfs = fs_b; pvs = vs_b; pvk = vb_b; phs = hs_b;
    end
    chk("b_fs_first", fs1, 3);
    chk("b_fs_period", fs2 - fs1, 1995);
    chk("b_fs_width", fs_w, 1);
    chk("b_vsync_rise", vs_r, 1476);
    chk("b_vsync_width", vs_f - vs_r, 210);
    chk("b_vblank_rise", vk_r, 1263);
    chk("b_vblank_width", vk_f - vk_r, 735);
    chk("b_hsync_rise", hs_r1, 78);
    chk("b_hsync_width", hs_f - hs_r1, 18);
    chk("b_hsync_period", hs_r2 - hs_r1, 105);
    chk("b_bounds_violations", bad, 0);

    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (row_b == 8 && col_b == 10) begin
        found = 1'b1;
        break;
      end
    end
    chk("b_reach_line8_px10", found, 1);
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1 chk_obs("b_async_reset", ob, z);
    repeat (3) @(posedge clk);
    #2 rst_b = 1'b1;
    pfs = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (fs_b && !pfs) begin
        if (fsa < 0) fsa = nb;
        else if (fsb < 0) fsb = nb;
      end
      pfs = fs_b;
    end
    chk("b_fs_after_reset", fsa, 3);
    chk("b_fs_full_frame", fsb, 1998);
  endtask

  initial begin
    obs_t ra;
    repeat (2) @(negedge clk);
    ra       = '0;
    ra.hsync = 1'b1;
    ra.vsync = 1'b1;
    chk_obs("a_reset_state", oa, ra);
    ra = '0;
    chk_obs("b_reset_state", ob, ra);
    @(posedge clk);
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    fork
      seq_a();
      seq_b();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
